// File: rtl/mul_issue_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_writeback
// Description : Control stage around a non-stallable pipelined multiplier.
//               Issues RV32M multiply ops, tracks them with a valid/op/tag
//               shift register aligned to the multiplier latency, selects
//               the product half and buffers results in a ready/valid FIFO.
//               Issue is gated by credits so the FIFO can never overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_writeback #(
    parameter int MUL_LATENCY = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 5
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              flush,
    input  logic              issueValid,
    output logic              issueReady,
    input  logic [1:0]        issueOp,
    input  logic [31:0]       issueOp1,
    input  logic [31:0]       issueOp2,
    input  logic [TAG_W-1:0]  issueTag,
    output logic              mulSignOp1,
    output logic              mulSignOp2,
    output logic [31:0]       mulOp1,
    output logic [31:0]       mulOp2,
    input  logic [63:0]       mulProduct,
    output logic              resultValid,
    input  logic              resultReady,
    output logic [31:0]       resultData,
    output logic [TAG_W-1:0]  resultTag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = $clog2(MUL_LATENCY + FIFO_DEPTH + 1);

    localparam logic [1:0] c_OP_MUL    = 2'd0;
    localparam logic [1:0] c_OP_MULH   = 2'd1;
    localparam logic [1:0] c_OP_MULHSU = 2'd2;

    // Tracking shift register, one entry per multiplier stage
    logic [MUL_LATENCY-1:0] r_vld;
    logic [1:0]             r_op  [MUL_LATENCY];
    logic [TAG_W-1:0]       r_tag [MUL_LATENCY];

    // Result FIFO storage and bookkeeping
    logic [31:0]            r_mem_data [FIFO_DEPTH];
    logic [TAG_W-1:0]       r_mem_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CRD_W-1:0]       w_inflight;
    logic [CRD_W-1:0]       w_used;
    logic [31:0]            w_capture;

    // Operands go straight through; the multiplier only sees them on accept cycles
    // that matter, because untracked products are never captured.
    assign mulOp1     = issueOp1;
    assign mulOp2     = issueOp2;
    assign mulSignOp1 = (issueOp == c_OP_MULH) || (issueOp == c_OP_MULHSU);
    assign mulSignOp2 = (issueOp == c_OP_MULH);

    // Count ops currently travelling through the multiplier
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            w_inflight = w_inflight + CRD_W'(r_vld[i]);
        end
    end

    // Every accepted op owns a FIFO slot from issue until it is popped;
    // a pop frees its credit only from the following cycle.
    assign w_used     = w_inflight + CRD_W'(r_count);
    assign issueReady = rstN && !flush && (w_used < CRD_W'(FIFO_DEPTH));
    assign w_accept   = issueValid && issueReady;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign resultValid = !w_empty;
    assign w_pop       = resultValid && resultReady;
    assign w_push      = r_vld[MUL_LATENCY-1] && !flush;

    // Low half for MUL, high half for all the MULH variants
    assign w_capture = (r_op[MUL_LATENCY-1] == c_OP_MUL) ? mulProduct[31:0]
                                                         : mulProduct[63:32];

    assign resultData = w_empty ? '0 : r_mem_data[r_rptr];
    assign resultTag  = w_empty ? '0 : r_mem_tag[r_rptr];

    // Advance the tracking pipeline every cycle; flush kills all valid bits
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_vld <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                r_op[i]  <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_op[0]  <= issueOp;
            r_tag[0] <= issueTag;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_op[i]  <= r_op[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            if (flush) begin
                r_vld <= '0;
            end
        end
    end

    // Write the selected product half and its tag at the FIFO tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_capture;
            r_mem_tag[r_wptr]  <= r_tag[MUL_LATENCY-1];
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Credit gating must make a write into a full, non-draining FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstN)
                                    !(w_push && w_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue_writeback
// Description : Directed self-checking bench for mul_issue_writeback with a
//               behavioural pipelined multiplier of matching latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue_writeback;

    localparam int L  = 4;
    localparam int D  = 4;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          flush = 1'b0;
    logic          issueValid = 1'b0;
    logic          issueReady;
    logic [1:0]    issueOp = '0;
    logic [31:0]   issueOp1 = '0;
    logic [31:0]   issueOp2 = '0;
    logic [TW-1:0] issueTag = '0;
    logic          mulSignOp1, mulSignOp2;
    logic [31:0]   mulOp1, mulOp2;
    logic [63:0]   mulProduct;
    logic          resultValid;
    logic          resultReady = 1'b0;
    logic [31:0]   resultData;
    logic [TW-1:0] resultTag;

    int n_vec = 0;
    int n_err = 0;

    mul_issue_writeback #(.MUL_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .issueValid(issueValid), .issueReady(issueReady), .issueOp(issueOp),
        .issueOp1(issueOp1), .issueOp2(issueOp2), .issueTag(issueTag),
        .mulSignOp1(mulSignOp1), .mulSignOp2(mulSignOp2),
        .mulOp1(mulOp1), .mulOp2(mulOp2), .mulProduct(mulProduct),
        .resultValid(resultValid), .resultReady(resultReady),
        .resultData(resultData), .resultTag(resultTag)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: operands sampled at the issue edge, product
    // visible L cycles after the issue cycle.
    logic [63:0] m_a, m_b, m_p;
    logic [63:0] m_pipe [L];
    always_comb begin
        m_a = mulSignOp1 ? {{32{mulOp1[31]}}, mulOp1} : {32'd0, mulOp1};
        m_b = mulSignOp2 ? {{32{mulOp2[31]}}, mulOp2} : {32'd0, mulOp2};
        m_p = m_a * m_b;
    end
    always @(posedge clk) begin
        m_pipe[0] <= m_p;
        for (int i = 1; i < L; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign mulProduct = m_pipe[L-1];

    // Wait for resultValid, dropping issueValid; reports cycles waited
    task automatic wait_valid(input int max, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int n = 1; n <= max; n++) begin
            @(negedge clk);
            issueValid = 1'b0;
            #1;
            if (resultValid) begin
                ok = 1'b1;
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (resultValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", resultValid); end
        n_vec++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", issueReady); end
        n_vec++; if (resultData !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", resultData); end
        n_vec++; if (resultTag !== '0) begin n_err++; $display("FAIL reset_tag: got %h want 0", resultTag); end
        @(negedge clk);
        rstN = 1'b1;
        #1;
        n_vec++; if (issueReady !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", issueReady); end
    endtask

    task automatic test_mul_latency();
        @(negedge clk);
        issueValid = 1'b1; issueOp = 2'd0; issueOp1 = 32'd7; issueOp2 = 32'hFFFF_FFFD;
        issueTag = 5'd5; resultReady = 1'b1;
        #1;
        n_vec++; if (issueReady !== 1'b1) begin n_err++; $display("FAIL mul_ready: got %b want 1", issueReady); end
        n_vec++; if ({mulSignOp1, mulSignOp2} !== 2'b00) begin n_err++; $display("FAIL mul_signs: got %b want 00", {mulSignOp1, mulSignOp2}); end
        n_vec++; if (mulOp1 !== 32'd7 || mulOp2 !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mul_operands: got %h %h want 7 fffffffd", mulOp1, mulOp2); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            issueValid = 1'b0;
            #1;
            if (k == 5) begin
                n_vec++; if (resultValid !== 1'b1) begin n_err++; $display("FAIL mul_latency: got valid %b want 1 at cycle 5", resultValid); end
                n_vec++; if (resultData !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_data: got %h want ffffffeb", resultData); end
                n_vec++; if (resultTag !== 5'd5) begin n_err++; $display("FAIL mul_tag: got %0d want 5", resultTag); end
            end else begin
                n_vec++; if (resultValid !== 1'b0) begin n_err++; $display("FAIL mul_early_late: got valid %b want 0 at cycle %0d", resultValid, k); end
            end
        end
    endtask

    task automatic test_high_ops();
        logic [1:0]  ops   [3] = '{2'd1, 2'd2, 2'd3};
        logic [1:0]  signs [3] = '{2'b11, 2'b10, 2'b00};
        logic [31:0] exp   [3] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        bit ok;
        int cyc;
        resultReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issueValid = 1'b1; issueOp = ops[i]; issueOp1 = 32'h8000_0000;
            issueOp2 = 32'hFFFF_FFFF; issueTag = 5'(20 + i);
            #1;
            n_vec++; if ({mulSignOp1, mulSignOp2} !== signs[i]) begin n_err++; $display("FAIL hi_signs op%0d: got %b want %b", ops[i], {mulSignOp1, mulSignOp2}, signs[i]); end
            wait_valid(12, ok, cyc);
            n_vec++; if (!ok) begin n_err++; $display("FAIL hi_timeout op%0d: got no result want result", ops[i]); end
            n_vec++; if (resultData !== exp[i]) begin n_err++; $display("FAIL hi_data op%0d: got %h want %h", ops[i], resultData, exp[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        int got = 0;
        int exp_tags [4] = '{11, 12, 13, 20};
        resultReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issueValid = 1'b1; issueOp = 2'd0; issueOp1 = 32'(10 + i); issueOp2 = 32'd3;
            issueTag = 5'(10 + i);
            #1;
            if (issueReady) accepted++;
            if (i == 4) begin
                n_vec++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop: got %b want 0", issueReady); end
            end
        end
        n_vec++; if (accepted != 4) begin n_err++; $display("FAIL b2b_accepted: got %0d want 4", accepted); end
        // FIFO now full; start draining and keep offering tag 20
        @(negedge clk);
        issueTag = 5'd20; issueOp1 = 32'd20; resultReady = 1'b1;
        #1;
        n_vec++; if (resultValid !== 1'b1 || resultTag !== 5'd10) begin n_err++; $display("FAIL b2b_head: got valid %b tag %0d want 1 10", resultValid, resultTag); end
        n_vec++; if (resultData !== 32'd30) begin n_err++; $display("FAIL b2b_head_data: got %0d want 30", resultData); end
        n_vec++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL b2b_pop_no_credit: got %b want 0", issueReady); end
        @(negedge clk);
        #1;
        n_vec++; if (issueReady !== 1'b1) begin n_err++; $display("FAIL b2b_resume: got %b want 1", issueReady); end
        for (int n = 0; n < 20 && got < 4; n++) begin
            if (n > 0) begin @(negedge clk); issueValid = 1'b0; #1; end
            if (resultValid) begin
                n_vec++; if (resultTag !== 5'(exp_tags[got])) begin n_err++; $display("FAIL b2b_order: got tag %0d want %0d", resultTag, exp_tags[got]); end
                n_vec++; if (resultData !== 32'(exp_tags[got] * 3)) begin n_err++; $display("FAIL b2b_data: got %0d want %0d", resultData, exp_tags[got] * 3); end
                got++;
            end
        end
        n_vec++; if (got != 4) begin n_err++; $display("FAIL b2b_drain: got %0d results want 4", got); end
        @(negedge clk);
    endtask

    task automatic test_continuous();
        int sent = 0;
        int got = 0;
        int rcyc [8];
        resultReady = 1'b1;
        for (int n = 0; n < 60 && got < 8; n++) begin
            @(negedge clk);
            issueValid = (sent < 8); issueOp = 2'd0; issueOp1 = 32'(100 + sent);
            issueOp2 = 32'd2; issueTag = 5'(1 + sent);
            #1;
            if (resultValid) begin
                n_vec++; if (resultTag !== 5'(1 + got)) begin n_err++; $display("FAIL cont_order: got tag %0d want %0d", resultTag, 1 + got); end
                n_vec++; if (resultData !== 32'((100 + got) * 2)) begin n_err++; $display("FAIL cont_data: got %0d want %0d", resultData, (100 + got) * 2); end
                rcyc[got] = n;
                got++;
            end
            if (issueValid && issueReady) sent++;
        end
        issueValid = 1'b0;
        n_vec++; if (got != 8) begin n_err++; $display("FAIL cont_count: got %0d want 8", got); end
        n_vec++; if (rcyc[0] != 5) begin n_err++; $display("FAIL cont_latency: got %0d want 5", rcyc[0]); end
        n_vec++; if (rcyc[3] - rcyc[0] != 3) begin n_err++; $display("FAIL cont_bubble: got span %0d want 3", rcyc[3] - rcyc[0]); end
    endtask

    task automatic test_flush();
        bit ok;
        int cyc;
        int seen = 0;
        resultReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            issueValid = (i < 3) || (i == 4); issueOp = 2'd0; issueOp1 = 32'd9;
            issueOp2 = 32'd9; issueTag = 5'(1 + i);
            flush = (i == 4);
            #1;
            if (i == 4) begin
                n_vec++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", issueReady); end
            end
            if (resultValid) seen++;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            flush = 1'b0; issueValid = 1'b0;
            #1;
            if (resultValid) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_stale: got %0d results want 0", seen); end
        @(negedge clk);
        issueValid = 1'b1; issueOp = 2'd3; issueOp1 = 32'hFFFF_FFFF; issueOp2 = 32'hFFFF_FFFF;
        issueTag = 5'd9;
        #1;
        wait_valid(12, ok, cyc);
        n_vec++; if (!ok || cyc != 5) begin n_err++; $display("FAIL flush_after_latency: got ok %b cycles %0d want 1 5", ok, cyc); end
        n_vec++; if (resultData !== 32'hFFFF_FFFE || resultTag !== 5'd9) begin n_err++; $display("FAIL flush_after_data: got %h tag %0d want fffffffe 9", resultData, resultTag); end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        resultReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issueValid = (i == 0) || (i == 3) || (i == 4); issueOp = 2'd0;
            issueOp1 = 32'd5; issueOp2 = 32'd5; issueTag = 5'(1 + i);
            #1;
        end
        n_vec++; if (resultValid !== 1'b1 || resultTag !== 5'd1) begin n_err++; $display("FAIL rst_buffered: got valid %b tag %0d want 1 1", resultValid, resultTag); end
        #2;
        rstN = 1'b0;
        #1;
        n_vec++; if (resultValid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", resultValid); end
        n_vec++; if (issueReady !== 1'b0 || resultData !== 32'd0) begin n_err++; $display("FAIL rst_async_out: got ready %b data %h want 0 0", issueReady, resultData); end
        @(negedge clk);
        rstN = 1'b1; resultReady = 1'b1;
        #1;
        n_vec++; if (issueReady !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", issueReady); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (resultValid) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rst_stale: got %0d results want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_high_ops();
        test_back_to_back();
        test_continuous();
        test_flush();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
